// File: rtl/skew_loader.sv
// Loads one N-row tile into a skew buffer (one row per handshake), then drains
// it with 2N-1 enable cycles that freeze while the downstream stalls.
module skew_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  localparam int PTR_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  localparam int CNT_W = $clog2(2 * ARRAY_SIZE)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]    in_data,
  input  logic                                            stall,
  output logic                                            write,
  output logic        [PTR_W-1:0]                         row_ptr,
  output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0]    data_out,
  output logic                                            enable,
  output logic                                            busy,
  output logic                                            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ROW    = CNT_W'(ARRAY_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_ENABLE = CNT_W'(2 * ARRAY_SIZE - 2);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   row_cnt_reg, row_cnt_next;
  logic [CNT_W-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [PTR_W-1:0]   row_ptr_reg, row_ptr_next;
  logic               write_reg, write_next;
  logic               capture;

  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_reg;

  always_comb begin
    state_next     = state_reg;
    row_cnt_next   = row_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    row_ptr_next   = row_ptr_reg;
    write_next     = 1'b0;
    capture        = 1'b0;
    in_ready       = 1'b0;
    enable         = 1'b0;
    done           = 1'b0;
    busy           = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = LOAD;
          row_cnt_next   = '0;
          drain_cnt_next = '0;
          row_ptr_next   = '0;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture      = 1'b1;
          write_next   = 1'b1;
          row_ptr_next = row_cnt_reg[PTR_W-1:0];
          row_cnt_next = row_cnt_reg + 1'b1;
          if (row_cnt_reg == LAST_ROW) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The first DRAIN cycle still carries the last row's write strobe.
        enable = !write_reg && !stall;
        if (enable) begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
          if (drain_cnt_reg == LAST_ENABLE) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      row_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      row_ptr_reg   <= '0;
      write_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_cnt_reg   <= row_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      row_ptr_reg   <= row_ptr_next;
      write_reg     <= write_next;
    end
  end

  // One holding register per systolic row lane.
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg[gi] <= '0;
      end else if (capture) begin
        data_reg[gi] <= in_data[gi];
      end
    end
  end

  assign write    = write_reg;
  assign row_ptr  = row_ptr_reg;
  assign data_out = data_reg;

endmodule

// File: doc/skew_loader.md
SKEW_LOADER -- requirements
Module: skew_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bit width of one signed matrix element.
REQ-002 Parameter ARRAY_SIZE, default 4, number of rows per tile and number of elements per row (N).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  request to load and drain one tile; sampled only in IDLE.
REQ-006 in_valid  input  1  upstream row valid.
REQ-007 in_ready  output  1  loader accepts a row; a row transfers when in_valid and in_ready are both 1 at a rising edge.
REQ-008 in_data  input  N x DATA_WIDTH signed  one tile row; element j feeds systolic row j.
REQ-009 stall  input  1  downstream hold; freezes the drain phase.
REQ-010 write  output  1  skew-buffer row write strobe.
REQ-011 row_ptr  output  $clog2(N)  skew-buffer row index for the current write.
REQ-012 data_out  output  N x DATA_WIDTH signed  row presented to the skew-buffer data_in.
REQ-013 enable  output  1  skew-buffer read/shift enable.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a tile has fully drained.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-017 IDLE: in_ready=0, write=0, enable=0; start=1 moves to LOAD at the next edge and clears row counter and drain counter.
REQ-018 LOAD: in_ready=1 combinationally; each handshake registers in_data into data_out, row counter into row_ptr, sets write=1 for exactly the next cycle, and increments the row counter.
REQ-019 The write latency SHALL be one cycle: a row accepted at edge k appears with write=1 from edge k to edge k+1.
REQ-020 Cycles without a handshake in LOAD SHALL drive write=0 and hold data_out and row_ptr unchanged.
REQ-021 Handshake of row N-1 SHALL move the FSM to DRAIN at the same edge; in_ready=0 from then on until the next tile.
REQ-022 enable SHALL be 0 in the first DRAIN cycle, which is the final write cycle; write and enable are never both 1.
REQ-023 From the second DRAIN cycle on, enable = not stall, combinationally; the drain counter increments only on cycles with enable=1.
REQ-024 After 2N-1 enable cycles (7 for N=4), DRAIN SHALL move to DONE; stall cycles add latency but never add or drop enable cycles.
REQ-025 DONE SHALL last exactly one cycle with done=1 and enable=0, then return to IDLE.
REQ-026 start SHALL be ignored outside IDLE; start asserted in the DONE cycle is ignored.
REQ-027 in_valid outside LOAD SHALL be ignored and never cause write.
REQ-028 Counters SHALL be sized to hold 2N-1 without overflow; row_ptr wraps to 0 at the start of each tile.
REQ-029 Minimum tile time without stalls or upstream bubbles SHALL be 1 (IDLE) + N (LOAD) + 1 + (2N-1) (DRAIN) + 1 (DONE) cycles.

Reset
REQ-030 With rst=1 the FSM SHALL enter IDLE at the next edge; write, enable, done, busy, in_ready and row_ptr are 0, and data_out is all zeros.
REQ-031 rst SHALL take priority over all other inputs in every state; a reset mid-LOAD or mid-DRAIN abandons the tile with no done pulse.

Verification (N=4, DATA_WIDTH=8)
REQ-032 Reset then start, rows i=0..3 with element j = 4i+j, in_valid held high -> write high 4 consecutive cycles, row_ptr 0,1,2,3, data_out rows {0..3},{4..7},{8..11},{12..15}; enable low in the final write cycle, then high 7 cycles; done pulses once.
REQ-033 Upstream bubble: in_valid low 2 cycles between rows 1 and 2 -> write low in those cycles; row_ptr holds at 1 and data_out holds {4..7}; the tile otherwise matches REQ-032.
REQ-034 stall high for 1 cycle after the 1st enable cycle, then for 2 cycles after the 4th -> enable low exactly in those 3 cycles, total enable cycles still 7, done delayed by 3 cycles.
REQ-035 start and in_valid pulsed during DRAIN and during DONE -> no state change, no write, in_ready stays 0.
REQ-036 rst asserted after row 2 is written -> at the next edge all outputs are 0 and the FSM is in IDLE with no done pulse; a following start reloads from row_ptr=0.
REQ-037 Two back-to-back tiles, start asserted in the IDLE cycle after done -> the second tile repeats the REQ-032 sequence exactly with the new data.
